urv_trap_ctrl: RTL and testbench
================================

URV_TRAP_CTRL -- requirements
Module: urv_trap_ctrl

Interface
REQ-001 Parameter TRAP_VECTOR, default 32'h00000008, fixed trap entry address.
REQ-002 clk_i  in  1  sole clock, rising edge.
REQ-003 rst_i  in  1  reset, asynchronous, active-high.
REQ-004 x_stall_i  in  1  execute stage stalled, so no state commits.
REQ-005 x_kill_i  in  1  execute-stage instruction squashed, so no state commits.
REQ-006 d_is_csr_i  in  1  CSR instruction in execute.
REQ-007 d_csr_sel_i  in  12  CSR address.
REQ-008 x_csr_write_value_i  in  32  new CSR value from CSR datapath.
REQ-009 x_exception_i  in  1  synchronous exception in execute.
REQ-010 x_exception_cause_i  in  4  exception code.
REQ-011 x_exception_pc_i  in  32  PC of faulting or interrupted instruction.
REQ-012 d_is_mret_i  in  1  MRET in execute.
REQ-013 irq_i  in  1  external interrupt, level-sensitive.
REQ-014 timer_tick_i  in  1  timer compare pulse, one cycle.
REQ-015 x_irq_ack_i  in  1  pipeline accepts pending interrupt; PC is on x_exception_pc_i.
REQ-016 x_irq_o  out  1  interrupt request to pipeline.
REQ-017 x_trap_vector_o  out  32  equals TRAP_VECTOR.
REQ-018 x_mret_target_o  out  32  equals csr_mepc_o.
REQ-019 csr_mstatus_o, csr_mip_o, csr_mie_o, csr_mepc_o, csr_mcause_o  out  32 each  CSR read values.

Function
REQ-020 A commit cycle is a cycle where !x_stall_i && !x_kill_i.
REQ-021 mstatus layout:
- MIE is bit 3.
- MPIE is bit 7.
- All other bits read 0.
REQ-022 mip layout:
- MTIP is bit 7, sticky.
- MEIP is bit 11, equal to irq_i registered once.
- All other bits read 0.
REQ-023 mie holds writable bits 7 and 11 only; other bits read 0.
REQ-024 mepc holds bits [31:2] only; bits [1:0] are always 0.
REQ-025 mcause is bit 31 (interrupt flag) plus bits [3:0] (code); other bits are 0.
REQ-026 A CSR write occurs on a commit cycle with d_is_csr_i at address:
- mstatus 0x300: MIE and MPIE load from the value.
- mie 0x304: bits 7 and 11 load.
- mepc 0x341: bits [31:2] load.
- mcause 0x342: bits 31 and [3:0] load.
- mip 0x344: a 0 in bit 7 clears MTIP; writing 1 has no effect.
REQ-027 timer_tick_i sets MTIP on the next edge regardless of stall.
- If a tick coincides with an MTIP-clearing write, the set wins.
REQ-028 pending = mip & mie; x_irq_o = MIE && pending != 0 && !x_exception_i, combinational.
REQ-029 Interrupt entry happens on x_irq_ack_i with x_irq_o high, on a commit cycle:
- mepc <= x_exception_pc_i.
- mcause <= {1, code}; code is 11 if MEIP is pending, else 7 (external has priority).
- MPIE <= MIE; MIE <= 0.
REQ-030 Exception entry happens on x_exception_i on a commit cycle:
- mepc <= x_exception_pc_i.
- mcause <= {0, x_exception_cause_i}.
- MPIE <= MIE; MIE <= 0.
REQ-031 MRET happens on d_is_mret_i on a commit cycle: MIE <= MPIE, MPIE <= 1.
REQ-032 Priority within one commit cycle is exception > interrupt ack > MRET > CSR write; lower-priority updates are discarded.
REQ-033 x_irq_ack_i while x_irq_o is low is ignored.
REQ-034 All state updates take effect at the edge; CSR outputs reflect them the next cycle. There is no further latency.
REQ-035 Stalled or killed cycles change no state except MTIP set and the MEIP sample.

Reset
REQ-036 Asynchronous reset, active-high, sets:
- mstatus = 0 (MIE = 0, MPIE = 0).
- mie = 0, mepc = 0, mcause = 0.
- MTIP = 0, MEIP register = 0.
REQ-037 During reset x_irq_o = 0 and CSR outputs read 0; reset asserted mid-trap aborts all updates.

Verification
REQ-038 Write mstatus=0x8, mie=0x800, then raise irq_i -> x_irq_o high within 2 cycles; ack with PC 0x1234 -> mepc=0x1234, mcause=0x8000000B, mstatus=0x80.
REQ-039 MRET after REQ-038 -> mstatus=0x88.
REQ-040 x_exception_i cause 2, PC 0x101, simultaneous ack and CSR write of mepc -> mepc=0x100, mcause=0x2, CSR write lost.
REQ-041 timer_tick_i with mie=0x80, MIE=1 -> mip=0x80, x_irq_o high, mcause on ack = 0x80000007; write mip=0 -> MTIP cleared; tick and clear same cycle -> MTIP=1.
REQ-042 irq_i and MTIP both pending -> mcause code 11; with x_stall_i high, ack has no effect.
REQ-043 Assert rst_i asynchronously mid-operation -> all CSR outputs 0 and x_irq_o 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/urv_trap_ctrl.sv
// Machine-mode trap controller: mstatus/mie/mip/mepc/mcause CSRs, interrupt request and trap entry/return.
// Updates land on the clock edge of a commit cycle; the interrupt request is combinational.
module urv_trap_ctrl #(
    parameter logic [31:0] TRAP_VECTOR = 32'h00000008
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        x_stall_i,
    input  logic        x_kill_i,
    input  logic        d_is_csr_i,
    input  logic [11:0] d_csr_sel_i,
    input  logic [31:0] x_csr_write_value_i,
    input  logic        x_exception_i,
    input  logic [3:0]  x_exception_cause_i,
    input  logic [31:0] x_exception_pc_i,
    input  logic        d_is_mret_i,
    input  logic        irq_i,
    input  logic        timer_tick_i,
    input  logic        x_irq_ack_i,
    output logic        x_irq_o,
    output logic [31:0] x_trap_vector_o,
    output logic [31:0] x_mret_target_o,
    output logic [31:0] csr_mstatus_o,
    output logic [31:0] csr_mip_o,
    output logic [31:0] csr_mie_o,
    output logic [31:0] csr_mepc_o,
    output logic [31:0] csr_mcause_o
);

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MIE     = 12'h304;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MIP     = 12'h344;

    logic        mstatus_mie;
    logic        mstatus_mpie;
    logic        mip_mtip;
    logic        mip_meip;
    logic        mie_mtie;
    logic        mie_meie;
    logic [29:0] mepc;
    logic        mcause_irq;
    logic [3:0]  mcause_code;

    logic commit;
    logic pend_timer;
    logic pend_ext;
    logic take_exc;
    logic take_irq;
    logic take_mret;
    logic csr_wr;
    logic unused_pc_lsb;

    assign commit     = !x_stall_i && !x_kill_i;
    assign pend_timer = mip_mtip && mie_mtie;
    assign pend_ext   = mip_meip && mie_meie;
    assign x_irq_o    = mstatus_mie && (pend_timer || pend_ext) && !x_exception_i;

    // Strict priority: exception > interrupt ack > mret > csr write
    assign take_exc  = commit && x_exception_i;
    assign take_irq  = commit && x_irq_ack_i && x_irq_o;
    assign take_mret = commit && d_is_mret_i && !take_exc && !take_irq;
    assign csr_wr    = commit && d_is_csr_i && !take_exc && !take_irq && !d_is_mret_i;

    assign unused_pc_lsb = ^x_exception_pc_i[1:0];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mstatus_mie  <= 1'b0;
            mstatus_mpie <= 1'b0;
            mip_mtip     <= 1'b0;
            mip_meip     <= 1'b0;
            mie_mtie     <= 1'b0;
            mie_meie     <= 1'b0;
            mepc         <= '0;
            mcause_irq   <= 1'b0;
            mcause_code  <= '0;
        end else begin
            mip_meip <= irq_i;

            // A timer tick beats a simultaneous software clear
            if (timer_tick_i)
                mip_mtip <= 1'b1;
            else if (csr_wr && d_csr_sel_i == CSR_MIP && !x_csr_write_value_i[7])
                mip_mtip <= 1'b0;

            if (take_exc) begin
                mepc         <= x_exception_pc_i[31:2];
                mcause_irq   <= 1'b0;
                mcause_code  <= x_exception_cause_i;
                mstatus_mpie <= mstatus_mie;
                mstatus_mie  <= 1'b0;
            end else if (take_irq) begin
                mepc         <= x_exception_pc_i[31:2];
                mcause_irq   <= 1'b1;
                mcause_code  <= pend_ext ? 4'd11 : 4'd7;
                mstatus_mpie <= mstatus_mie;
                mstatus_mie  <= 1'b0;
            end else if (take_mret) begin
                mstatus_mie  <= mstatus_mpie;
                mstatus_mpie <= 1'b1;
            end else if (csr_wr) begin
                case (d_csr_sel_i)
                    CSR_MSTATUS: begin
                        mstatus_mie  <= x_csr_write_value_i[3];
                        mstatus_mpie <= x_csr_write_value_i[7];
                    end
                    CSR_MIE: begin
                        mie_mtie <= x_csr_write_value_i[7];
                        mie_meie <= x_csr_write_value_i[11];
                    end
                    CSR_MEPC:   mepc <= x_csr_write_value_i[31:2];
                    CSR_MCAUSE: begin
                        mcause_irq  <= x_csr_write_value_i[31];
                        mcause_code <= x_csr_write_value_i[3:0];
                    end
                    default: ;
                endcase
            end
        end
    end

    assign x_trap_vector_o = TRAP_VECTOR;
    assign x_mret_target_o = csr_mepc_o;
    assign csr_mstatus_o   = {24'b0, mstatus_mpie, 3'b0, mstatus_mie, 3'b0};
    assign csr_mip_o       = {20'b0, mip_meip, 3'b0, mip_mtip, 7'b0};
    assign csr_mie_o       = {20'b0, mie_meie, 3'b0, mie_mtie, 7'b0};
    assign csr_mepc_o      = {mepc, 2'b00};
    assign csr_mcause_o    = {mcause_irq, 27'b0, mcause_code};

endmodule

// File: tb/tb_urv_trap_ctrl.sv
// Directed bench for urv_trap_ctrl: expected CSR snapshots queued as each step is driven, checked after the edge.
module tb_urv_trap_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        x_stall_i = 1'b0;
    logic        x_kill_i = 1'b0;
    logic        d_is_csr_i = 1'b0;
    logic [11:0] d_csr_sel_i = '0;
    logic [31:0] x_csr_write_value_i = '0;
    logic        x_exception_i = 1'b0;
    logic [3:0]  x_exception_cause_i = '0;
    logic [31:0] x_exception_pc_i = '0;
    logic        d_is_mret_i = 1'b0;
    logic        irq_i = 1'b0;
    logic        timer_tick_i = 1'b0;
    logic        x_irq_ack_i = 1'b0;
    logic        x_irq_o;
    logic [31:0] x_trap_vector_o;
    logic [31:0] x_mret_target_o;
    logic [31:0] csr_mstatus_o;
    logic [31:0] csr_mip_o;
    logic [31:0] csr_mie_o;
    logic [31:0] csr_mepc_o;
    logic [31:0] csr_mcause_o;

    urv_trap_ctrl #(.TRAP_VECTOR(32'h00000008)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .x_stall_i(x_stall_i), .x_kill_i(x_kill_i),
        .d_is_csr_i(d_is_csr_i), .d_csr_sel_i(d_csr_sel_i), .x_csr_write_value_i(x_csr_write_value_i),
        .x_exception_i(x_exception_i), .x_exception_cause_i(x_exception_cause_i),
        .x_exception_pc_i(x_exception_pc_i), .d_is_mret_i(d_is_mret_i), .irq_i(irq_i),
        .timer_tick_i(timer_tick_i), .x_irq_ack_i(x_irq_ack_i), .x_irq_o(x_irq_o),
        .x_trap_vector_o(x_trap_vector_o), .x_mret_target_o(x_mret_target_o),
        .csr_mstatus_o(csr_mstatus_o), .csr_mip_o(csr_mip_o), .csr_mie_o(csr_mie_o),
        .csr_mepc_o(csr_mepc_o), .csr_mcause_o(csr_mcause_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [31:0] mstatus;
        logic [31:0] mip;
        logic [31:0] mie;
        logic [31:0] mepc;
        logic [31:0] mcause;
        logic        irq;
    } snap_t;

    snap_t exp_q[$];
    snap_t e;
    int    n_assert = 0;
    int    n_fail   = 0;

    task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_pop(input string tag);
        snap_t x;
        if (exp_q.size() == 0) begin
            n_assert++;
            n_fail++;
            $error("FAIL %s scoreboard empty observed=0 expected=1", tag);
        end else begin
            x = exp_q.pop_front();
            cmp({tag, ".mstatus"}, csr_mstatus_o, x.mstatus);
            cmp({tag, ".mip"},     csr_mip_o,     x.mip);
            cmp({tag, ".mie"},     csr_mie_o,     x.mie);
            cmp({tag, ".mepc"},    csr_mepc_o,    x.mepc);
            cmp({tag, ".mcause"},  csr_mcause_o,  x.mcause);
            cmp({tag, ".irq"},     {31'b0, x_irq_o}, {31'b0, x.irq});
            cmp({tag, ".mret"},    x_mret_target_o, x.mepc);
        end
    endtask

    task automatic idle();
        x_stall_i = 0; x_kill_i = 0; d_is_csr_i = 0; d_csr_sel_i = '0;
        x_csr_write_value_i = '0; x_exception_i = 0; x_exception_cause_i = '0;
        x_exception_pc_i = '0; d_is_mret_i = 0; timer_tick_i = 0; x_irq_ack_i = 0;
    endtask

    // Inputs for the step are already driven; queue the expectation, clock once, then check.
    task automatic step(input string tag);
        exp_q.push_back(e);
        @(posedge clk_i);
        #1;
        idle();
        check_pop(tag);
    endtask

    task automatic csr(input logic [11:0] a, input logic [31:0] v);
        d_is_csr_i = 1; d_csr_sel_i = a; x_csr_write_value_i = v;
    endtask

    initial begin
        idle();
        e = '0;
        repeat (2) @(posedge clk_i);
        #1;
        exp_q.push_back(e);
        check_pop("reset");
        cmp("trap_vector", x_trap_vector_o, 32'h00000008);
        rst_i = 0;

        // External interrupt entry and return
        csr(12'h300, 32'h8);      e.mstatus = 32'h08;                 step("wr_mstatus");
        csr(12'h304, 32'h800);    e.mie = 32'h800;                    step("wr_mie");
        irq_i = 1;                e.mip = 32'h800; e.irq = 1;         step("irq_raise");
        x_irq_ack_i = 1; x_exception_pc_i = 32'h1234;
        e.mepc = 32'h1234; e.mcause = 32'h8000000B; e.mstatus = 32'h80; e.irq = 0;
        step("irq_ack");
        d_is_mret_i = 1;          e.mstatus = 32'h88; e.irq = 1;      step("mret");

        // Exception beats ack and csr write in the same cycle
        irq_i = 0;
        x_exception_i = 1; x_exception_cause_i = 4'd2; x_exception_pc_i = 32'h101;
        x_irq_ack_i = 1; csr(12'h341, 32'h5550);
        e.mepc = 32'h100; e.mcause = 32'h2; e.mstatus = 32'h80; e.mip = 32'h0; e.irq = 0;
        step("exception");

        // Timer interrupt, software clear, tick-vs-clear race
        csr(12'h304, 32'h80);     e.mie = 32'h80;                     step("wr_mie_t");
        csr(12'h300, 32'h8);      e.mstatus = 32'h08;                 step("wr_mstatus_t");
        timer_tick_i = 1;         e.mip = 32'h80; e.irq = 1;          step("tick");
        x_irq_ack_i = 1; x_exception_pc_i = 32'h2000;
        e.mepc = 32'h2000; e.mcause = 32'h80000007; e.mstatus = 32'h80; e.irq = 0;
        step("timer_ack");
        csr(12'h344, 32'h0);      e.mip = 32'h0;                      step("clr_mtip");
        csr(12'h344, 32'h0); timer_tick_i = 1; e.mip = 32'h80;        step("tick_vs_clr");

        // Both sources pending: external code wins; stalled ack does nothing
        irq_i = 1; csr(12'h304, 32'h880); e.mie = 32'h880; e.mip = 32'h880; step("wr_mie_both");
        csr(12'h300, 32'h8);      e.mstatus = 32'h08; e.irq = 1;      step("wr_mstatus_both");
        x_stall_i = 1; x_irq_ack_i = 1; x_exception_pc_i = 32'h3000;  step("stalled_ack");
        x_kill_i = 1; csr(12'h341, 32'h7770);                         step("killed_wr");
        x_irq_ack_i = 1; x_exception_pc_i = 32'h3000;
        e.mepc = 32'h3000; e.mcause = 32'h8000000B; e.mstatus = 32'h80; e.irq = 0;
        step("both_ack");
        x_irq_ack_i = 1; x_exception_pc_i = 32'h4000;                 step("ack_ignored");
        csr(12'h342, 32'hFFFF_FFF5); e.mcause = 32'h80000005;         step("wr_mcause");

        // Asynchronous reset between edges
        @(posedge clk_i);
        #2;
        rst_i = 1;
        #1;
        e = '0;
        exp_q.push_back(e);
        check_pop("async_rst");
        irq_i = 0;
        @(posedge clk_i);
        #1;
        rst_i = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
